grn_node_multi: RTL and testbench
=================================

// Module: grn_node_multi
// PURPOSE
//   Parametrised Boolean gene-regulatory-network node: NCH independent state copies (channels).
//   Each channel evaluates an NIN-input truth-table function of its regulator bits.
//   Update is gated by a per-node start-pulse divider (DELAY), which models slower-acting genes.
//   Each channel also reports change/settle information for attractor detection.
//   One instance per network gene, fed by the network sequencer's per-channel start strobes.
// PARAMETERS
//   NCH    2        number of independent state copies (channels), >=1
//   NIN    2        regulator inputs per channel, 1..6
//   FUNC   4'b1000  truth table, width 2**NIN; next = FUNC[{in_(NIN-1),...,in_0}] (default = AND)
//   DELAY  1        start pulses skipped between evaluations, 0..255 (0 = evaluate on every start)
//   CNTW   8        width of the per-channel saturating change counter
// PORTS
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         asynchronous, active-low reset
//   reset_nos  in   1         synchronous network re-initialise, all channels
//   init_state in   NCH       per-channel value loaded on reset_nos
//   start      in   NCH       per-channel evaluation strobe, one cycle wide
//   in_bits    in   NCH*NIN   regulator bits; channel c occupies [c*NIN +: NIN]
//   state      out  NCH       current node state per channel (registered)
//   upd        out  NCH       1-cycle pulse: state[c] was just (re)evaluated
//   changed    out  NCH       last evaluation altered state[c] (level, held)
//   chg_cnt    out  NCH*CNTW  saturating count of state changes since init, per channel
// BEHAVIOUR
//   - Async reset (rst_n=0): state=0, upd=0, changed=0, chg_cnt=0, divider cnt=0. Applies immediately, mid-operation included.
//   - Priority per cycle: rst_n > reset_nos > start[c]. Channels are fully independent.
//   - reset_nos=1: state[c]<=init_state[c], cnt<=0, upd<=0, changed<=0, chg_cnt<=0.
//     Any start asserted in the same cycle is ignored.
//   - start[c]=1 and cnt==0 (evaluate):
//       nxt = FUNC[in_bits_c]; state<=nxt; upd<=1; changed<=(nxt!=state); cnt<=DELAY.
//       chg_cnt += (nxt!=state), saturating at 2**CNTW-1, no wrap.
//   - start[c]=1 and cnt!=0 (skip): cnt<=cnt-1; state, changed and chg_cnt held; upd<=0.
//   - start[c]=0: upd<=0; everything else held.
//   - Latency: inputs are sampled in the start cycle; state, upd and changed are visible the next cycle.
//   - First start after reset_nos always evaluates (cnt==0).
//     Steady pattern is 1 evaluation per DELAY+1 starts.
//   - in_bits is sampled only in evaluating cycles; in_bits with X/Z outside those cycles has no effect.
//   - Divider width DW = max(1, clog2(DELAY+1)). DELAY=0 keeps cnt constant at 0.
// STRUCTURE
//   - Shared package grn_pkg: clog2 function, max-NIN/DELAY legality checks (elaboration error if violated).
//   - Sub-module grn_node_ch: one channel (state, divider, upd/changed, counter).
//     Top is a generate loop over NCH channels plus port slicing.
//   - FUNC, DELAY and CNTW are passed unchanged to every channel.
// TESTING
//   1 reset: rst_n=0 asserted mid-run with DELAY=1 and counters nonzero
//       -> all outputs 0 within the same cycle; cnt=0 after release.
//   2 AND, DELAY=1, NCH=2: reset_nos with init=2'b11, then in_bits=4'b1111 and start=2'b11 four times
//       -> updates on starts 1 and 3 only; state stays 2'b11; changed=0; chg_cnt=0.
//   3 DELAY=0, FUNC=4'b0110 (XOR): ch0 inputs toggle 00,01,11,10 with start every cycle
//       -> state 0,1,0,1 one cycle later; chg_cnt=3; upd high each cycle.
//   4 Saturation, CNTW=2: force 5 state changes on ch1
//       -> chg_cnt[ch1]=3 held; ch0 unaffected.
//   5 Collision: reset_nos and start same cycle, init=2'b01 -> state=2'b01, upd=0;
//       next start evaluates regardless of DELAY.
//   6 NIN=3, FUNC=8'hE8 (majority), DELAY=2: 6 starts with inputs 3'b011
//       -> evaluations on starts 1 and 4 only, each setting state=1.

Source files
------------

// File: rtl/grn_pkg.sv
// ----------------------------------------------------------------------------
// grn_pkg : shared helpers and legality checks for GRN nodes.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package grn_pkg;

  localparam int MAX_NIN   = 6;
  localparam int MAX_DELAY = 255;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // A zero-width divider is not representable, so DELAY=0 still gets one bit.
  function automatic int div_width(input int delay);
    int w;
    w = clog2(delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_ok(input int nch, input int nin, input int delay,
                                   input int cntw);
    return (nch >= 1) && (nin >= 1) && (nin <= MAX_NIN) &&
           (delay >= 0) && (delay <= MAX_DELAY) && (cntw >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grn_node_ch.sv
// ----------------------------------------------------------------------------
// grn_node_ch : one GRN node channel (state, divider, upd/changed, counter). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module grn_node_ch
  import grn_pkg::*;
#(
  parameter int                NIN   = 2,
  parameter logic [2**NIN-1:0] FUNC  = 4'b1000,
  parameter int                DELAY = 1,
  parameter int                CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reset_nos,
  input  logic            init_state,
  input  logic            start,
  input  logic [NIN-1:0]  in_bits,
  output logic            state,
  output logic            upd,
  output logic            changed,
  output logic [CNTW-1:0] chg_cnt
);

  localparam int DW = div_width(DELAY);

  logic [DW-1:0] r_cnt;
  logic          w_nxt;
  logic          w_diff;

  assign w_nxt  = FUNC[in_bits];
  assign w_diff = w_nxt ^ state;

  // w_nxt is only consumed in evaluating cycles, so X on in_bits elsewhere is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= 1'b0;
      upd     <= 1'b0;
      changed <= 1'b0;
      chg_cnt <= '0;
      r_cnt   <= '0;
    end else if (reset_nos) begin
      state   <= init_state;
      upd     <= 1'b0;
      changed <= 1'b0;
      chg_cnt <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      if (r_cnt == '0) begin
        state   <= w_nxt;
        upd     <= 1'b1;
        changed <= w_diff;
        r_cnt   <= DW'(DELAY);
        if (w_diff && (chg_cnt != {CNTW{1'b1}})) begin
          chg_cnt <= chg_cnt + 1'b1;
        end
      end else begin
        upd   <= 1'b0;
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      upd <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/grn_node_multi.sv
// ----------------------------------------------------------------------------
// grn_node_multi : multi-channel Boolean GRN node, one channel per state copy. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module grn_node_multi
  import grn_pkg::*;
#(
  parameter int                NCH   = 2,
  parameter int                NIN   = 2,
  parameter logic [2**NIN-1:0] FUNC  = 4'b1000,
  parameter int                DELAY = 1,
  parameter int                CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reset_nos,
  input  logic [NCH-1:0]      init_state,
  input  logic [NCH-1:0]      start,
  input  logic [NCH*NIN-1:0]  in_bits,
  output logic [NCH-1:0]      state,
  output logic [NCH-1:0]      upd,
  output logic [NCH-1:0]      changed,
  output logic [NCH*CNTW-1:0] chg_cnt
);

  if (!params_ok(NCH, NIN, DELAY, CNTW)) begin : g_bad_params
    $error("grn_node_multi: illegal NCH/NIN/DELAY/CNTW parameter combination");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    grn_node_ch #(
      .NIN   (NIN),
      .FUNC  (FUNC),
      .DELAY (DELAY),
      .CNTW  (CNTW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .reset_nos  (reset_nos),
      .init_state (init_state[c]),
      .start      (start[c]),
      .in_bits    (in_bits[c*NIN +: NIN]),
      .state      (state[c]),
      .upd        (upd[c]),
      .changed    (changed[c]),
      .chg_cnt    (chg_cnt[c*CNTW +: CNTW])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_grn_node_multi.sv
// ----------------------------------------------------------------------------
// tb_grn_node_multi : directed self-checking bench for grn_node_multi. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_grn_node_multi;

  logic clk;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: AND, DELAY=1, CNTW=8
  logic        a_nos;
  logic [1:0]  a_init, a_start, a_state, a_upd, a_changed;
  logic [3:0]  a_in;
  logic [15:0] a_cnt;

  // dut_x: XOR, DELAY=0, CNTW=2
  logic        x_nos;
  logic [1:0]  x_init, x_start, x_state, x_upd, x_changed;
  logic [3:0]  x_in;
  logic [3:0]  x_cnt;

  // dut_m: NIN=3 majority, DELAY=2, single channel
  logic        m_nos;
  logic [0:0]  m_init, m_start, m_state, m_upd, m_changed;
  logic [2:0]  m_in;
  logic [7:0]  m_cnt;

  grn_node_multi #(.NCH(2), .NIN(2), .FUNC(4'b1000), .DELAY(1), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .reset_nos(a_nos), .init_state(a_init), .start(a_start),
    .in_bits(a_in), .state(a_state), .upd(a_upd), .changed(a_changed), .chg_cnt(a_cnt)
  );

  grn_node_multi #(.NCH(2), .NIN(2), .FUNC(4'b0110), .DELAY(0), .CNTW(2)) dut_x (
    .clk(clk), .rst_n(rst_n), .reset_nos(x_nos), .init_state(x_init), .start(x_start),
    .in_bits(x_in), .state(x_state), .upd(x_upd), .changed(x_changed), .chg_cnt(x_cnt)
  );

  grn_node_multi #(.NCH(1), .NIN(3), .FUNC(8'hE8), .DELAY(2), .CNTW(8)) dut_m (
    .clk(clk), .rst_n(rst_n), .reset_nos(m_nos), .init_state(m_init), .start(m_start),
    .in_bits(m_in), .state(m_state), .upd(m_upd), .changed(m_changed), .chg_cnt(m_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] xor_pat [4];
    logic       xor_exp [4];
    logic [1:0] sat_exp [5];
    xor_pat = '{2'b00, 2'b01, 2'b11, 2'b10};
    xor_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0;
    a_nos = 1'b0; a_init = '0; a_start = '0; a_in = '0;
    x_nos = 1'b0; x_init = '0; x_start = '0; x_in = '0;
    m_nos = 1'b0; m_init = '0; m_start = '0; m_in = '0;
    tick; tick;
    chk("rst_state",   32'(a_state),   32'h0);
    chk("rst_upd",     32'(a_upd),     32'h0);
    chk("rst_changed", 32'(a_changed), 32'h0);
    chk("rst_cnt",     32'(a_cnt),     32'h0);
    rst_n = 1'b1;

    // AND, DELAY=1: evaluations on starts 1 and 3 only
    a_nos = 1'b1; a_init = 2'b11;
    tick;
    a_nos = 1'b0;
    chk("and_init_state", 32'(a_state), 32'h3);
    a_in = 4'b1111; a_start = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk($sformatf("and_upd_s%0d", k),   32'(a_upd),   (k % 2 == 1) ? 32'h3 : 32'h0);
      chk($sformatf("and_state_s%0d", k), 32'(a_state), 32'h3);
      chk($sformatf("and_chg_s%0d", k),   32'(a_changed), 32'h0);
      chk($sformatf("and_cnt_s%0d", k),   32'(a_cnt),   32'h0);
    end
    a_start = 2'b00;
    tick;
    chk("and_upd_idle", 32'(a_upd), 32'h0);

    // Collision: divider left mid-count, then reset_nos together with start
    a_start = 2'b11;
    tick;
    a_nos = 1'b1; a_init = 2'b01;
    tick;
    a_nos = 1'b0;
    chk("col_state", 32'(a_state), 32'h1);
    chk("col_upd",   32'(a_upd),   32'h0);
    a_in = 4'b1100;
    tick;
    chk("col_eval_upd",   32'(a_upd),     32'h3);
    chk("col_eval_state", 32'(a_state),   32'h2);
    chk("col_eval_chg",   32'(a_changed), 32'h3);
    chk("col_eval_cnt",   32'(a_cnt),     32'h0101);
    a_start = 2'b00;

    // Asynchronous reset mid-cycle with nonzero counters
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(a_state),   32'h0);
    chk("arst_upd",   32'(a_upd),     32'h0);
    chk("arst_chg",   32'(a_changed), 32'h0);
    chk("arst_cnt",   32'(a_cnt),     32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    a_in = 4'b1111; a_start = 2'b11;
    tick;
    chk("arst_rel_upd",   32'(a_upd),   32'h3);
    chk("arst_rel_state", 32'(a_state), 32'h3);
    chk("arst_rel_cnt",   32'(a_cnt),   32'h0101);
    a_start = 2'b00;

    // XOR, DELAY=0 on ch0: start every cycle
    x_nos = 1'b1; x_init = 2'b00;
    tick;
    x_nos = 1'b0;
    x_start = 2'b01;
    for (int k = 0; k < 4; k++) begin
      x_in[1:0] = xor_pat[k];
      tick;
      chk($sformatf("xor_state_%0d", k), 32'(x_state[0]), 32'(xor_exp[k]));
      chk($sformatf("xor_upd_%0d", k),   32'(x_upd),      32'h1);
    end
    chk("xor_cnt", 32'(x_cnt[1:0]), 32'h3);

    // Saturation on ch1 (CNTW=2); ch0 inputs driven X while ch0 is idle
    x_start = 2'b10;
    x_in[1:0] = 2'bxx;
    for (int k = 0; k < 5; k++) begin
      x_in[3:2] = (k % 2 == 0) ? 2'b01 : 2'b00;
      tick;
      chk($sformatf("sat_cnt_%0d", k),   32'(x_cnt[3:2]), 32'(sat_exp[k]));
      chk($sformatf("sat_state_%0d", k), 32'(x_state[1]), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    chk("sat_ch0_cnt",   32'(x_cnt[1:0]), 32'h3);
    chk("sat_ch0_state", 32'(x_state[0]), 32'h1);
    x_start = 2'b00;

    // Majority, NIN=3, DELAY=2: evaluations on starts 1 and 4
    m_nos = 1'b1; m_init = 1'b0;
    tick;
    m_nos = 1'b0;
    m_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      m_in = (k == 1 || k == 4) ? 3'b011 : 3'bxxx;
      tick;
      chk($sformatf("maj_upd_s%0d", k),   32'(m_upd),   (k == 1 || k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("maj_state_s%0d", k), 32'(m_state), 32'h1);
    end
    chk("maj_cnt",     32'(m_cnt),     32'h1);
    chk("maj_changed", 32'(m_changed), 32'h0);
    m_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
